// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the FP adder back end: field widths, special exponent
// and result encodings, and the state encoding of the normalise/round stage.
// -----------------------------------------------------------------------------
package fp_pkg;

  localparam int EXP_W  = 8;             // exponent width
  localparam int MANT_W = 23;            // stored mantissa width
  localparam int SUM_W  = MANT_W + 2;    // carry + hidden + fraction

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Packed single-precision special values.
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] INF_POS = 32'h7F80_0000;
  localparam logic [31:0] INF_NEG = 32'hFF80_0000;

  // Safety bound on left shifts. A non-zero legal sum reaches the hidden bit
  // in at most MANT_W shifts, so this limit is never the deciding condition.
  localparam logic [4:0] MAX_SHIFTS = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } norm_state_t;

endpackage : fp_pkg

// File: rtl/fp_pack.sv
// -----------------------------------------------------------------------------
// fp_pack
// Combinational assembly of a packed IEEE-754 single from sign, exponent and
// mantissa fields, with the zero and overflow-to-infinity cases folded in.
//
// Ports
//   sign        in   1        result sign (ignored for a zero result)
//   exp         in   EXP_W    biased exponent
//   mant        in   MANT_W   stored fraction
//   force_inf   in   1        emit signed infinity, raise ovf
//   force_zero  in   1        emit +0, raise zero (wins over force_inf)
//   result      out  32       {sign, exp, mant}
//   ovf         out  1        result overflowed to infinity
//   zero        out  1        result is exact zero
// -----------------------------------------------------------------------------
module fp_pack
  import fp_pkg::*;
(
  input  logic              sign,
  input  logic [EXP_W-1:0]  exp,
  input  logic [MANT_W-1:0] mant,
  input  logic              force_inf,
  input  logic              force_zero,
  output logic [31:0]       result,
  output logic              ovf,
  output logic              zero
);

  // NOTE: every output gets a default at the top of the block so that no
  // path through the if-chain leaves a value unassigned, which would infer a latch.
  always_comb begin
    result = {sign, exp, mant};
    ovf    = 1'b0;
    zero   = 1'b0;
    if (force_zero) begin
      // An exact zero is always +0 regardless of the operand signs.
      result = '0;
      zero   = 1'b1;
    end else if (force_inf) begin
      result = {sign, EXP_MAX, {MANT_W{1'b0}}};
      ovf    = 1'b1;
    end
  end

endmodule : fp_pack

// File: rtl/fp_norm_round_stage.sv
// -----------------------------------------------------------------------------
// fp_norm_round_stage
// Stage 3 of the FP adder. Consumes the stage-2 pipeline register (unsigned
// 25-bit magnitude sum, common exponent, sign/control bits), normalises it one
// left shift per cycle and emits a packed single. Rounding is truncation; no
// guard bits reach this stage, so a right shift on carry simply drops bit 0.
// Valid/ready handshakes on both sides absorb the variable latency.
//
// Ports
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous active-high reset
//   in_valid     in   1       stage-2 data valid
//   in_ready     out  1       stage can accept (IDLE and not in reset)
//   intmdt_sum2  in   SUM_W   magnitude; [24]=carry, [23]=hidden bit
//   exp_a2       in   EXP_W   common (larger) exponent
//   sign_a2      in   1       sign of operand A
//   sign_b2      in   1       sign of operand B
//   xor2         in   1       effective subtraction
//   s2           in   1       magnitude was negated (|B|>|A|)
//   out_valid    out  1       result valid, held until out_ready
//   out_ready    in   1       downstream accepts result
//   out_result   out  32      {sign, exp, mantissa}
//   out_ovf      out  1       overflow to infinity
//   out_zero     out  1       exact zero result
// -----------------------------------------------------------------------------
module fp_norm_round_stage
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SUM_W-1:0]  intmdt_sum2,
  input  logic [EXP_W-1:0]  exp_a2,
  input  logic              sign_a2,
  input  logic              sign_b2,
  input  logic              xor2,
  input  logic              s2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_ovf,
  output logic              out_zero
);

  norm_state_t       state;
  logic [SUM_W-1:0]  sum_r;
  logic [EXP_W-1:0]  exp_r;
  logic              sign_r;
  logic [4:0]        shift_cnt;

  // On an effective subtraction where B's magnitude won, the result takes B's sign.
  logic rsign_in;
  assign rsign_in = (xor2 & s2) ? sign_b2 : sign_a2;

  // in_ready depends on state only (plus reset), never on in_valid.
  assign in_ready = (state == ST_IDLE) && !rst;

  // ---------------------------------------------------------------------------
  // Per-cycle normalisation decision while in NORM.
  // ---------------------------------------------------------------------------
  logic              finish;
  logic              shift_left;
  logic              pk_sign;
  logic [EXP_W-1:0]  pk_exp;
  logic [MANT_W-1:0] pk_mant;
  logic              pk_inf;
  logic              pk_zero;
  logic [EXP_W-1:0]  exp_inc;

  assign exp_inc = exp_r + 8'd1;

  always_comb begin
    finish     = 1'b0;
    shift_left = 1'b0;
    pk_sign    = sign_r;
    pk_exp     = exp_r;
    pk_mant    = sum_r[MANT_W-1:0];
    pk_inf     = 1'b0;
    pk_zero    = 1'b0;

    if (exp_r == EXP_MAX) begin
      // Inf/NaN operand: pass the payload through unchanged.
      finish = 1'b1;
    end else if (sum_r == '0) begin
      finish  = 1'b1;
      pk_zero = 1'b1;
    end else if (sum_r[SUM_W-1]) begin
      // Carry out: renormalise right by one, truncating the dropped bit.
      finish  = 1'b1;
      pk_exp  = exp_inc;
      pk_mant = sum_r[MANT_W:1];
      pk_inf  = (exp_inc == EXP_MAX);
    end else if (sum_r[MANT_W]) begin
      finish = 1'b1;
    end else if ((exp_r <= 8'd1) || (shift_cnt == MAX_SHIFTS)) begin
      // Cannot shift further without leaving the normal range: emit denormal.
      finish = 1'b1;
      pk_exp = '0;
    end else begin
      shift_left = 1'b1;
    end
  end

  logic [31:0] pk_result;
  logic        pk_ovf;
  logic        pk_zero_flag;

  fp_pack u_pack (
    .sign       (pk_sign),
    .exp        (pk_exp),
    .mant       (pk_mant),
    .force_inf  (pk_inf),
    .force_zero (pk_zero),
    .result     (pk_result),
    .ovf        (pk_ovf),
    .zero       (pk_zero_flag)
  );

  // ---------------------------------------------------------------------------
  // FSM, shifter, counter and registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset along with control; they are
      // few flops and this keeps the outputs deterministic after reset.
      state      <= ST_IDLE;
      sum_r      <= '0;
      exp_r      <= '0;
      sign_r     <= 1'b0;
      shift_cnt  <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
      out_zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sum_r     <= intmdt_sum2;
            exp_r     <= exp_a2;
            sign_r    <= rsign_in;
            shift_cnt <= '0;
            state     <= ST_NORM;
          end
        end

        ST_NORM: begin
          if (finish) begin
            out_result <= pk_result;
            out_ovf    <= pk_ovf;
            out_zero   <= pk_zero_flag;
            out_valid  <= 1'b1;
            state      <= ST_DONE;
          end else if (shift_left) begin
            sum_r     <= sum_r << 1;
            exp_r     <= exp_r - 8'd1;
            shift_cnt <= shift_cnt + 5'd1;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : fp_norm_round_stage

// File: tb/tb_fp_norm_round_stage.sv
// -----------------------------------------------------------------------------
// tb_fp_norm_round_stage
// Directed, table-driven bench for the FP normalise/round stage. Each record
// carries the stage-2 inputs and the hand-computed packed result, flags and
// latency (edges from acceptance to out_valid, i.e. 1 + left shifts).
// -----------------------------------------------------------------------------
module tb_fp_norm_round_stage;

  import fp_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [SUM_W-1:0]  intmdt_sum2;
  logic [EXP_W-1:0]  exp_a2;
  logic              sign_a2;
  logic              sign_b2;
  logic              xor2;
  logic              s2;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic              out_ovf;
  logic              out_zero;

  fp_norm_round_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .intmdt_sum2 (intmdt_sum2),
    .exp_a2      (exp_a2),
    .sign_a2     (sign_a2),
    .sign_b2     (sign_b2),
    .xor2        (xor2),
    .s2          (s2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_ovf     (out_ovf),
    .out_zero    (out_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [24:0] sum;
    logic [7:0]  exp;
    logic        sa;
    logic        sb;
    logic        xr;
    logic        s2;
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    int          lat;
  } vec_t;

  // Drive one transaction, wait (bounded) for the result, compare it, then
  // keep out_ready low for 'hold' cycles checking the result is held before
  // releasing it.
  task automatic run_vec(input string tag, input vec_t v, input int hold);
    int lat;
    logic [31:0] first;
    @(negedge clk);
    intmdt_sum2 = v.sum;
    exp_a2      = v.exp;
    sign_a2     = v.sa;
    sign_b2     = v.sb;
    xor2        = v.xr;
    s2          = v.s2;
    in_valid    = 1'b1;
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " result"}, out_result, v.res);
    check({tag, " ovf"}, 32'(out_ovf), 32'(v.ovf));
    check({tag, " zero"}, 32'(out_zero), 32'(v.zero));
    first = out_result;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      check({tag, " held valid"}, 32'(out_valid), 32'd1);
      check({tag, " held result"}, out_result, first);
      check({tag, " held in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " valid cleared"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[15];

  initial begin
    //          sum           exp    sa    sb    xr    s2    result         ovf   zero  lat
    vecs[0]  = '{25'h1000000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 1};  // 1.0+1.0
    vecs[1]  = '{25'h0200000, 8'd127, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3E80_0000, 1'b0, 1'b0, 3};  // 1.5-1.25
    vecs[2]  = '{25'h0200000, 8'd127, 1'b0, 1'b1, 1'b1, 1'b1, 32'hBE80_0000, 1'b0, 1'b0, 3};  // negated
    vecs[3]  = '{25'h0000000, 8'd100, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1};  // cancel
    vecs[4]  = '{25'h1000000, 8'd254, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 1'b1, 1'b0, 1};  // overflow
    vecs[5]  = '{25'h0080000, 8'd3,   1'b0, 1'b0, 1'b1, 1'b0, 32'h0020_0000, 1'b0, 1'b0, 3};  // denormal
    vecs[6]  = '{25'h0C00000, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7FC0_0000, 1'b0, 1'b0, 1};  // NaN pass
    vecs[7]  = '{25'h0800001, 8'd130, 1'b1, 1'b1, 1'b0, 1'b0, 32'hC100_0001, 1'b0, 1'b0, 1};  // normal, neg
    vecs[8]  = '{25'h1000003, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4000_0001, 1'b0, 1'b0, 1};  // truncation
    vecs[9]  = '{25'h0000001, 8'd127, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3400_0000, 1'b0, 1'b0, 24}; // 23 shifts
    vecs[10] = '{25'h0400000, 8'd1,   1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0000, 1'b0, 1'b0, 1};  // exp=1 denorm
    vecs[11] = '{25'h0000010, 8'd0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0010, 1'b0, 1'b0, 1};  // exp=0 denorm
    vecs[12] = '{25'h0800000, 8'd127, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, 1};  // s2=0 keeps A sign
    vecs[13] = '{25'h0000000, 8'd90,  1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1};  // zero forces +0
    vecs[14] = '{25'h1000000, 8'd253, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F00_0000, 1'b0, 1'b0, 1};  // carry to 254

    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    intmdt_sum2 = '0;
    exp_a2      = '0;
    sign_a2     = 1'b0;
    sign_b2     = 1'b0;
    xor2        = 1'b0;
    s2          = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_result", out_result, 32'd0);
    check("reset out_ovf", 32'(out_ovf), 32'd0);
    check("reset out_zero", 32'(out_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 15; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i], 0);
    end

    // Backpressure: result and in_ready held for five cycles of out_ready=0.
    run_vec("bp", vecs[1], 5);

    // Reset while normalising a long (23-shift) operand drops it.
    @(negedge clk);
    intmdt_sum2 = 25'h0000001;
    exp_a2      = 8'd127;
    sign_a2     = 1'b0;
    sign_b2     = 1'b0;
    xor2        = 1'b1;
    s2          = 1'b0;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst-mid busy", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst-mid in_ready low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rst-mid out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst-mid idle", 32'(in_ready), 32'd1);
    begin
      int seen = 0;
      for (int c = 0; c < 30; c++) begin
        @(posedge clk);
        #1;
        if (out_valid) seen++;
      end
      check("rst-mid no result", 32'(seen), 32'd0);
    end
    check("rst-mid still idle", 32'(in_ready), 32'd1);

    // Recovery after the dropped transaction.
    run_vec("recover", vecs[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_fp_norm_round_stage
